rcg_div_upd_seq: RTL and testbench

RCG_DIV_UPD_SEQ -- requirements
Module: rcg_div_upd_seq

---
 rtl/rcg_pkg.sv | 22 ++
 rtl/rcg_tmo_cntr.sv | 32 +++
 rtl/rcg_div_upd_seq.sv | 172 +++++++++++++++++
 tb/tb_rcg_div_upd_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rcg_pkg.sv
// Shared definitions for the divider-update sequencer: FSM state encoding,
// the ratio value every divider powers up with, and the index width helper.
package rcg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_RELEASE  = 3'd3,
      ST_DONE     = 3'd4,
      ST_ERR      = 3'd5
   } upd_state_t;

   // Divide-by-one is the safe ratio that every divider starts from.
   localparam int unsigned DEF_RATIO = 1;

   // Width of an index selecting one of n entries (at least one bit).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rcg_tmo_cntr.sv
// Handshake timeout counter. Clear has priority over enable. The counter
// saturates at all-ones. 'expired' flags the cycle whose increment makes the
// count reach all-ones, so the owner can leave on that very edge.
module rcg_tmo_cntr #(
   parameter int TMO_WIDTH = 12
) (
   input  logic clk_in,
   input  logic grst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TMO_WIDTH-1:0] TMO_MAX  = {TMO_WIDTH{1'b1}};
   localparam logic [TMO_WIDTH-1:0] TMO_LAST = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

   logic [TMO_WIDTH-1:0] cnt;

   assign expired = en && !clr && (cnt == TMO_LAST);

   // Count cycles spent waiting on the dividers; restart on every new wait.
   always_ff @(posedge clk_in or posedge grst) begin
      if (grst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != TMO_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rcg_div_upd_seq.sv
// Divider ratio update sequencer. Software stages new ratios in shadow
// registers, then a single request applies the selected ones together and
// runs a go/ack handshake with each selected divider. A zero ratio, or a
// divider that never completes the handshake, ends the update in error.
module rcg_div_upd_seq
   import rcg_pkg::*;
#(
   parameter int DIV_NUM   = 4,
   parameter int DIV_WIDTH = 16,
   parameter int TMO_WIDTH = 12
) (
   input  logic                           clk_in,
   input  logic                           grst,
   input  logic                           cfg_wr_en,
   input  logic [idx_w(DIV_NUM)-1:0]      cfg_wr_idx,
   input  logic [DIV_WIDTH-1:0]           cfg_wr_data,
   input  logic [DIV_NUM-1:0]             upd_sel,
   input  logic                           upd_req,
   output logic [DIV_NUM*DIV_WIDTH-1:0]   div_ratio,
   output logic [DIV_NUM-1:0]             divider_go,
   input  logic [DIV_NUM-1:0]             divider_go_ack,
   output logic                           upd_busy,
   output logic                           upd_done,
   output logic                           upd_err,
   output logic                           wr_err
);

   localparam int IDX_W = idx_w(DIV_NUM);
   localparam logic [DIV_WIDTH-1:0] RATIO_RST = DIV_WIDTH'(DEF_RATIO);

   upd_state_t           state;
   logic [DIV_NUM-1:0]   sel_r;
   logic [DIV_WIDTH-1:0] shadow [DIV_NUM];

   logic illegal_req;
   logic ack_all;
   logic ack_none;
   logic tmo_clr;
   logic tmo_en;
   logic tmo_expired;

   // Acks are only meaningful on the dividers taking part in this update.
   assign ack_all  = ((divider_go_ack & sel_r) == sel_r);
   assign ack_none = ((divider_go_ack & sel_r) == '0);

   // Timer restarts whenever a new wait phase begins and runs while waiting.
   assign tmo_clr = (state == ST_LOAD) || ((state == ST_WAIT_ACK) && ack_all);
   assign tmo_en  = (state == ST_WAIT_ACK) || (state == ST_RELEASE);

   rcg_tmo_cntr #(
      .TMO_WIDTH (TMO_WIDTH)
   ) u_tmo_cntr (
      .clk_in  (clk_in),
      .grst    (grst),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   // Reject a request selecting a zero ratio; a same-cycle write is bypassed.
   always_comb begin
      illegal_req = 1'b0;
      for (int i = 0; i < DIV_NUM; i++) begin
         if (upd_sel[i]) begin
            if (((cfg_wr_en && (cfg_wr_idx == IDX_W'(i))) ? cfg_wr_data : shadow[i]) == '0) begin
               illegal_req = 1'b1;
            end
         end
      end
   end

   // Shadow ratio staging, accepted only while no update is in flight.
   always_ff @(posedge clk_in or posedge grst) begin
      if (grst) begin
         for (int i = 0; i < DIV_NUM; i++) begin
            shadow[i] <= RATIO_RST;
         end
      end else if (cfg_wr_en && (state == ST_IDLE)) begin
         for (int i = 0; i < DIV_NUM; i++) begin
            if (cfg_wr_idx == IDX_W'(i)) begin
               shadow[i] <= cfg_wr_data;
            end
         end
      end
   end

   // Update sequencer with registered go, ratio, and status outputs.
   always_ff @(posedge clk_in or posedge grst) begin
      if (grst) begin
         state      <= ST_IDLE;
         sel_r      <= '0;
         divider_go <= '0;
         upd_busy   <= 1'b0;
         upd_done   <= 1'b0;
         upd_err    <= 1'b0;
         wr_err     <= 1'b0;
         for (int i = 0; i < DIV_NUM; i++) begin
            div_ratio[i*DIV_WIDTH +: DIV_WIDTH] <= RATIO_RST;
         end
      end else begin
         upd_done <= 1'b0;
         if (cfg_wr_en && (state != ST_IDLE)) begin
            wr_err <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (upd_req) begin
                  sel_r    <= upd_sel;
                  wr_err   <= 1'b0;
                  upd_busy <= 1'b1;
                  upd_err  <= illegal_req;
                  if (illegal_req) begin
                     upd_done <= 1'b1;
                     state    <= ST_ERR;
                  end else begin
                     state    <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               for (int i = 0; i < DIV_NUM; i++) begin
                  if (sel_r[i]) begin
                     div_ratio[i*DIV_WIDTH +: DIV_WIDTH] <= shadow[i];
                  end
               end
               if (sel_r == '0) begin
                  upd_done <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  divider_go <= sel_r;
                  state      <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (ack_all) begin
                  divider_go <= '0;
                  state      <= ST_RELEASE;
               end else if (tmo_expired) begin
                  divider_go <= '0;
                  upd_err    <= 1'b1;
                  upd_done   <= 1'b1;
                  state      <= ST_ERR;
               end
            end
            ST_RELEASE: begin
               if (ack_none) begin
                  upd_done <= 1'b1;
                  state    <= ST_DONE;
               end else if (tmo_expired) begin
                  upd_err  <= 1'b1;
                  upd_done <= 1'b1;
                  state    <= ST_ERR;
               end
            end
            ST_DONE: begin
               upd_busy <= 1'b0;
               state    <= ST_IDLE;
            end
            ST_ERR: begin
               upd_busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               divider_go <= '0;
               upd_busy   <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rcg_div_upd_seq.sv
// Directed bench for the divider update sequencer (TMO_WIDTH = 4, so the
// handshake timeout is 15 cycles).
module tb_rcg_div_upd_seq;

   logic        clk_in;
   logic        grst;
   logic        cfg_wr_en;
   logic [1:0]  cfg_wr_idx;
   logic [15:0] cfg_wr_data;
   logic [3:0]  upd_sel;
   logic        upd_req;
   logic [63:0] div_ratio;
   logic [3:0]  divider_go;
   logic [3:0]  divider_go_ack;
   logic        upd_busy;
   logic        upd_done;
   logic        upd_err;
   logic        wr_err;

   int n_chk  = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int go_seen  = 0;

   rcg_div_upd_seq #(
      .DIV_NUM   (4),
      .DIV_WIDTH (16),
      .TMO_WIDTH (4)
   ) dut (
      .clk_in         (clk_in),
      .grst           (grst),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_wr_idx     (cfg_wr_idx),
      .cfg_wr_data    (cfg_wr_data),
      .upd_sel        (upd_sel),
      .upd_req        (upd_req),
      .div_ratio      (div_ratio),
      .divider_go     (divider_go),
      .divider_go_ack (divider_go_ack),
      .upd_busy       (upd_busy),
      .upd_done       (upd_done),
      .upd_err        (upd_err),
      .wr_err         (wr_err)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(negedge clk_in) begin
      if (upd_done === 1'b1) done_cnt++;
      if (divider_go !== 4'b0000) go_seen++;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [15:0] data);
      cfg_wr_en   = 1'b1;
      cfg_wr_idx  = idx;
      cfg_wr_data = data;
      tick();
      cfg_wr_en   = 1'b0;
   endtask

   task automatic send_req(input logic [3:0] sel);
      upd_sel = sel;
      upd_req = 1'b1;
      tick();
      upd_req = 1'b0;
   endtask

   task automatic test_reset();
      grst = 1'b1;
      cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0;
      upd_sel = '0; upd_req = 1'b0; divider_go_ack = '0;
      tick(); tick();
      n_chk++; if (div_ratio !== 64'h0001_0001_0001_0001) begin n_fail++; $display("FAIL reset_ratio: got %h want %h", div_ratio, 64'h0001_0001_0001_0001); end
      n_chk++; if (divider_go !== 4'b0000) begin n_fail++; $display("FAIL reset_go: got %b want 0000", divider_go); end
      n_chk++; if ({upd_busy, upd_done, upd_err, wr_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", {upd_busy, upd_done, upd_err, wr_err}); end
      grst = 1'b0;
      tick();
   endtask

   task automatic test_full_update();
      int d0;
      cfg_write(2'd0, 16'd4);
      cfg_write(2'd1, 16'd8);
      cfg_write(2'd2, 16'd2);
      cfg_write(2'd3, 16'd6);
      d0 = done_cnt;
      send_req(4'b1111);
      n_chk++; if (upd_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_load: got %b want 1", upd_busy); end
      n_chk++; if (divider_go !== 4'b0000) begin n_fail++; $display("FAIL full_go_early: got %b want 0000", divider_go); end
      tick();
      n_chk++; if (divider_go !== 4'b1111) begin n_fail++; $display("FAIL full_go_2cyc: got %b want 1111", divider_go); end
      n_chk++; if (div_ratio !== 64'h0006_0002_0008_0004) begin n_fail++; $display("FAIL full_ratio: got %h want %h", div_ratio, 64'h0006_0002_0008_0004); end
      tick(); tick();
      divider_go_ack = 4'b1111;
      tick();
      n_chk++; if (divider_go !== 4'b0000) begin n_fail++; $display("FAIL full_go_release: got %b want 0000", divider_go); end
      divider_go_ack = 4'b0000;
      tick();
      n_chk++; if (upd_done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", upd_done); end
      tick();
      n_chk++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL full_idle: got %b want 0", upd_busy); end
      n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL full_done_count: got %0d want %0d", done_cnt - d0, 1); end
      n_chk++; if (upd_err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b want 0", upd_err); end
   endtask

   task automatic test_partial_sel();
      cfg_write(2'd1, 16'd12);
      send_req(4'b0010);
      tick();
      n_chk++; if (divider_go !== 4'b0010) begin n_fail++; $display("FAIL part_go: got %b want 0010", divider_go); end
      n_chk++; if (div_ratio !== 64'h0006_0002_000C_0004) begin n_fail++; $display("FAIL part_ratio: got %h want %h", div_ratio, 64'h0006_0002_000C_0004); end
      divider_go_ack = 4'b0001; tick();
      divider_go_ack = 4'b0000; tick();
      divider_go_ack = 4'b0001; tick();
      n_chk++; if (divider_go !== 4'b0010) begin n_fail++; $display("FAIL part_unsel_ack: got %b want 0010", divider_go); end
      divider_go_ack = 4'b0011; tick();
      n_chk++; if (divider_go !== 4'b0000) begin n_fail++; $display("FAIL part_release: got %b want 0000", divider_go); end
      divider_go_ack = 4'b0001; tick();
      n_chk++; if (upd_done !== 1'b1) begin n_fail++; $display("FAIL part_done: got %b want 1", upd_done); end
      divider_go_ack = 4'b0000; tick();
      n_chk++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL part_idle: got %b want 0", upd_busy); end
   endtask

   task automatic test_illegal();
      int d0;
      int g0;
      cfg_write(2'd2, 16'd0);
      d0 = done_cnt;
      g0 = go_seen;
      send_req(4'b0100);
      n_chk++; if ({upd_err, upd_done, upd_busy} !== 3'b111) begin n_fail++; $display("FAIL ill_err_state: got %b want 111", {upd_err, upd_done, upd_busy}); end
      tick();
      n_chk++; if ({upd_busy, upd_err} !== 2'b01) begin n_fail++; $display("FAIL ill_sticky: got %b want 01", {upd_busy, upd_err}); end
      n_chk++; if (div_ratio !== 64'h0006_0002_000C_0004) begin n_fail++; $display("FAIL ill_ratio: got %h want %h", div_ratio, 64'h0006_0002_000C_0004); end
      n_chk++; if (go_seen !== g0) begin n_fail++; $display("FAIL ill_go: got %0d go cycles want 0", go_seen - g0); end
      n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL ill_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_wr_bypass();
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd3; cfg_wr_data = 16'd0;
      upd_sel = 4'b1000; upd_req = 1'b1;
      tick();
      cfg_wr_en = 1'b0; upd_req = 1'b0;
      n_chk++; if ({upd_err, upd_done} !== 2'b11) begin n_fail++; $display("FAIL byp_zero_err: got %b want 11", {upd_err, upd_done}); end
      tick();
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd3; cfg_wr_data = 16'd5;
      upd_sel = 4'b1000; upd_req = 1'b1;
      tick();
      cfg_wr_en = 1'b0; upd_req = 1'b0;
      n_chk++; if ({upd_busy, upd_err} !== 2'b10) begin n_fail++; $display("FAIL byp_accept: got %b want 10", {upd_busy, upd_err}); end
      tick();
      n_chk++; if (div_ratio !== 64'h0005_0002_000C_0004) begin n_fail++; $display("FAIL byp_ratio: got %h want %h", div_ratio, 64'h0005_0002_000C_0004); end
      n_chk++; if (divider_go !== 4'b1000) begin n_fail++; $display("FAIL byp_go: got %b want 1000", divider_go); end
      divider_go_ack = 4'b1000; tick();
      divider_go_ack = 4'b0000; tick();
      tick();
   endtask

   task automatic test_wr_err();
      cfg_write(2'd2, 16'd7);
      send_req(4'b0001);
      tick();
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_data = 16'd9;
      tick();
      cfg_wr_en = 1'b0;
      n_chk++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wrerr_set: got %b want 1", wr_err); end
      divider_go_ack = 4'b0001; tick();
      divider_go_ack = 4'b0000; tick();
      tick();
      n_chk++; if ({upd_busy, wr_err} !== 2'b01) begin n_fail++; $display("FAIL wrerr_sticky: got %b want 01", {upd_busy, wr_err}); end
      send_req(4'b0101);
      n_chk++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wrerr_clear: got %b want 0", wr_err); end
      tick();
      n_chk++; if (div_ratio !== 64'h0005_0007_000C_0004) begin n_fail++; $display("FAIL wrerr_ratio: got %h want %h", div_ratio, 64'h0005_0007_000C_0004); end
      divider_go_ack = 4'b0101; tick();
      divider_go_ack = 4'b0000; tick();
      tick();
   endtask

   task automatic test_timeout();
      send_req(4'b1000);
      tick();
      n_chk++; if (divider_go !== 4'b1000) begin n_fail++; $display("FAIL tmo_go: got %b want 1000", divider_go); end
      repeat (14) tick();
      n_chk++; if ({divider_go, upd_err} !== 5'b1000_0) begin n_fail++; $display("FAIL tmo_early: got %b want 10000", {divider_go, upd_err}); end
      tick();
      n_chk++; if ({divider_go, upd_err, upd_done} !== 6'b0000_11) begin n_fail++; $display("FAIL tmo_err: got %b want 000011", {divider_go, upd_err, upd_done}); end
      tick();
      n_chk++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got %b want 0", upd_busy); end
   endtask

   task automatic test_zero_sel();
      int d0;
      int g0;
      d0 = done_cnt;
      g0 = go_seen;
      send_req(4'b0000);
      n_chk++; if ({upd_busy, upd_err} !== 2'b10) begin n_fail++; $display("FAIL zsel_load: got %b want 10", {upd_busy, upd_err}); end
      tick();
      n_chk++; if (upd_done !== 1'b1) begin n_fail++; $display("FAIL zsel_done: got %b want 1", upd_done); end
      tick();
      n_chk++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL zsel_idle: got %b want 0", upd_busy); end
      n_chk++; if (go_seen !== g0) begin n_fail++; $display("FAIL zsel_go: got %0d go cycles want 0", go_seen - g0); end
      n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL zsel_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int d0;
      send_req(4'b0001);
      tick();
      divider_go_ack = 4'b0001;
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd1; cfg_wr_data = 16'd3;
      tick();
      cfg_wr_en = 1'b0;
      n_chk++; if ({upd_busy, divider_go, wr_err} !== 6'b1_0000_1) begin n_fail++; $display("FAIL rmid_release: got %b want 100001", {upd_busy, divider_go, wr_err}); end
      d0 = done_cnt;
      #2 grst = 1'b1;
      #1;
      n_chk++; if ({upd_busy, upd_done, upd_err, wr_err} !== 4'b0000) begin n_fail++; $display("FAIL rmid_status: got %b want 0000", {upd_busy, upd_done, upd_err, wr_err}); end
      n_chk++; if (divider_go !== 4'b0000) begin n_fail++; $display("FAIL rmid_go: got %b want 0000", divider_go); end
      n_chk++; if (div_ratio !== 64'h0001_0001_0001_0001) begin n_fail++; $display("FAIL rmid_ratio: got %h want %h", div_ratio, 64'h0001_0001_0001_0001); end
      divider_go_ack = 4'b0000;
      tick();
      grst = 1'b0;
      repeat (3) tick();
      n_chk++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - d0); end
      n_chk++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got %b want 0", upd_busy); end
   endtask

   initial begin
      test_reset();
      test_full_update();
      test_partial_sel();
      test_illegal();
      test_wr_bypass();
      test_wr_err();
      test_timeout();
      test_zero_sel();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
